// File: rtl/axis_traffic_gen.sv
// AXI4-Stream packet generator: fixed-length packets with counter or LFSR payload,
// programmable inter-packet gap, masked tkeep/tdata on the last beat.
`timescale 1ns/1ps
module axis_traffic_gen #(
  parameter int          DWIDTH    = 32,
  parameter int          LEN_WIDTH = 16,
  parameter int          GAP_WIDTH = 8,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            pkt_num,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic                   mode,
  output logic [DWIDTH-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DWIDTH/8-1:0]    m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            sent_pkt_cnt
);

  localparam int                 KW        = DWIDTH / 8;
  localparam int                 LANES     = DWIDTH / 32;
  localparam logic [31:0]        SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]        LFSR_TAPS = 32'h8020_0003;
  localparam logic [LEN_WIDTH:0] KW_L      = (LEN_WIDTH+1)'(KW);
  localparam logic [LEN_WIDTH:0] ONE_L     = (LEN_WIDTH+1)'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [LEN_WIDTH:0] beats_of(input logic [LEN_WIDTH-1:0] len);
    beats_of = ({1'b0, len} + KW_L - ONE_L) / KW_L;
  endfunction

  function automatic logic [KW-1:0] last_keep(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] rem;
    rem = {1'b0, len} % KW_L;
    last_keep = {KW{1'b0}};
    for (int b = 0; b < KW; b++) begin
      last_keep[b] = (rem == {(LEN_WIDTH+1){1'b0}}) || (int'(rem) > b);
    end
  endfunction

  function automatic logic [DWIDTH-1:0] mask_data(input logic [DWIDTH-1:0] d,
                                                  input logic [KW-1:0]     k);
    mask_data = {DWIDTH{1'b0}};
    for (int b = 0; b < KW; b++) begin
      mask_data[b*8 +: 8] = k[b] ? d[b*8 +: 8] : 8'h00;
    end
  endfunction

  logic [1:0]            state_q,       state_d;
  logic [31:0]           num_q,         num_d;
  logic [LEN_WIDTH-1:0]  len_q,         len_d;
  logic [GAP_WIDTH-1:0]  gap_q,         gap_d;
  logic                  mode_q,        mode_d;
  logic                  stop_q,        stop_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q,     gap_cnt_d;
  logic [LEN_WIDTH:0]    beat_in_pkt_q, beat_in_pkt_d;
  logic [31:0]           beat_idx_q,    beat_idx_d;
  logic [31:0]           lfsr_q,        lfsr_d;
  logic [63:0]           pkt_cnt_q,     pkt_cnt_d;
  logic [DWIDTH-1:0]     tdata_q,       tdata_d;
  logic [KW-1:0]         tkeep_q,       tkeep_d;
  logic                  tvalid_q,      tvalid_d;
  logic                  tlast_q,       tlast_d;
  logic                  busy_q,        busy_d;
  logic                  done_q,        done_d;

  logic                  accept_s;
  logic                  stop_seen_s;
  logic [LEN_WIDTH:0]    beats_cur_s;
  logic [LEN_WIDTH:0]    beats_nxt_s;
  logic [31:0]           word_s;

  assign accept_s    = tvalid_q & m_axis_tready;
  assign stop_seen_s = stop_q | stop;
  assign beats_cur_s = beats_of(len_q);

  // Run control FSM and per-run bookkeeping
  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    len_d         = len_q;
    gap_d         = gap_q;
    mode_d        = mode_q;
    stop_d        = stop_q;
    gap_cnt_d     = gap_cnt_q;
    beat_in_pkt_d = beat_in_pkt_q;
    beat_idx_d    = beat_idx_q;
    lfsr_d        = lfsr_q;
    pkt_cnt_d     = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (pkt_len != {LEN_WIDTH{1'b0}})) begin
          state_d       = ST_SEND;
          num_d         = pkt_num;
          len_d         = pkt_len;
          gap_d         = gap_cycles;
          mode_d        = mode;
          stop_d        = stop;
          beat_in_pkt_d = {(LEN_WIDTH+1){1'b0}};
          beat_idx_d    = 32'd0;
          lfsr_d        = SEED_EFF;
          pkt_cnt_d     = 64'd0;
        end else begin
          stop_d = 1'b0;
        end
      end
      ST_SEND: begin
        stop_d = stop_seen_s;
        if (accept_s) begin
          lfsr_d     = lfsr_step(lfsr_q);
          beat_idx_d = beat_idx_q + 32'd1;
          if (beat_in_pkt_q == beats_cur_s - ONE_L) begin
            beat_in_pkt_d = {(LEN_WIDTH+1){1'b0}};
            pkt_cnt_d     = pkt_cnt_q + 64'd1;
            if (((num_q != 32'd0) && (pkt_cnt_d == {32'h0, num_q})) || stop_seen_s) begin
              state_d = ST_FIN;
            end else if (gap_q != {GAP_WIDTH{1'b0}}) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end else begin
              state_d = ST_SEND;
            end
          end else begin
            beat_in_pkt_d = beat_in_pkt_q + ONE_L;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        stop_d = stop_seen_s;
        if (stop_seen_s) begin
          state_d = ST_FIN;
        end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output beat is built from next-state values so the registered outputs track the FSM
  always_comb begin
    beats_nxt_s = beats_of(len_d);
    word_s      = mode_d ? lfsr_d : beat_idx_d;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tkeep_d     = {KW{1'b0}};
    tdata_d     = {DWIDTH{1'b0}};
    if (state_d == ST_SEND) begin
      tvalid_d = 1'b1;
      tlast_d  = (beat_in_pkt_d == beats_nxt_s - ONE_L);
      tkeep_d  = tlast_d ? last_keep(len_d) : {KW{1'b1}};
      tdata_d  = mask_data({LANES{word_s}}, tkeep_d);
    end else begin
      tvalid_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      num_q         <= 32'd0;
      len_q         <= {LEN_WIDTH{1'b0}};
      gap_q         <= {GAP_WIDTH{1'b0}};
      mode_q        <= 1'b0;
      stop_q        <= 1'b0;
      gap_cnt_q     <= {GAP_WIDTH{1'b0}};
      beat_in_pkt_q <= {(LEN_WIDTH+1){1'b0}};
      beat_idx_q    <= 32'd0;
      lfsr_q        <= SEED_EFF;
      pkt_cnt_q     <= 64'd0;
      tdata_q       <= {DWIDTH{1'b0}};
      tkeep_q       <= {KW{1'b0}};
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      mode_q        <= mode_d;
      stop_q        <= stop_d;
      gap_cnt_q     <= gap_cnt_d;
      beat_in_pkt_q <= beat_in_pkt_d;
      beat_idx_q    <= beat_idx_d;
      lfsr_q        <= lfsr_d;
      pkt_cnt_q     <= pkt_cnt_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sent_pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen (DWIDTH=32, SEED=1) with immediate-assertion checks.
`timescale 1ns/1ps
module tb_axis_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode, m_axis_tready;
  logic [31:0] pkt_num;
  logic [15:0] pkt_len;
  logic [7:0]  gap_cycles;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, busy, done;
  logic [3:0]  m_axis_tkeep;
  logic [63:0] sent_pkt_cnt;

  int vec  = 0;
  int miss = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  int          q_cyc[$];

  axis_traffic_gen #(.DWIDTH(32), .LEN_WIDTH(16), .GAP_WIDTH(8), .SEED(32'h1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pkt_num(pkt_num),
    .pkt_len(pkt_len), .gap_cycles(gap_cycles), .mode(mode),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
    .sent_pkt_cnt(sent_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run, then collect accepted beats until done (bounded), checking AXI hold rules.
  task automatic run(input logic [31:0] num, input logic [15:0] len, input logic [7:0] gap,
                     input logic md, input bit stall, input int stop_after, input bit stop_now);
    logic        done_seen;
    logic        have_prev;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
    pkt_num = num; pkt_len = len; gap_cycles = gap; mode = md;
    start = 1'b1; stop = stop_now;
    tick();
    start = 1'b0; stop = 1'b0;
    pkt_num = 32'd7; pkt_len = 16'd5; gap_cycles = 8'd0; mode = ~md;
    done_seen = 1'b0; have_prev = 1'b0;
    prev_data = 32'h0; prev_keep = 4'h0; prev_last = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      m_axis_tready = stall ? (c % 2 == 1) : 1'b1;
      stop = (stop_after >= 0) && (q_data.size() == stop_after);
      if (have_prev) begin
        chk("hold_valid", {63'h0, m_axis_tvalid}, 64'd1);
        chk("hold_data",  {32'h0, m_axis_tdata},  {32'h0, prev_data});
        chk("hold_keep",  {60'h0, m_axis_tkeep},  {60'h0, prev_keep});
        chk("hold_last",  {63'h0, m_axis_tlast},  {63'h0, prev_last});
      end
      have_prev = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata; prev_keep = m_axis_tkeep; prev_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(c);
      end
      if (done) done_seen = 1'b1;
      tick();
    end
    stop = 1'b0; m_axis_tready = 1'b1;
    chk("done_seen", {63'h0, done_seen}, 64'd1);
    chk("done_pulse_1cyc", {63'h0, done}, 64'd0);
    chk("idle_after_run", {63'h0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; m_axis_tready = 1'b1;
    pkt_num = 32'd0; pkt_len = 16'd0; gap_cycles = 8'd0;
    tick(); tick();
    chk("rst_tvalid", {63'h0, m_axis_tvalid}, 64'd0);
    chk("rst_busy",   {63'h0, busy}, 64'd0);
    chk("rst_done",   {63'h0, done}, 64'd0);
    chk("rst_tkeep",  {60'h0, m_axis_tkeep}, 64'd0);
    chk("rst_tdata",  {32'h0, m_axis_tdata}, 64'd0);
    chk("rst_cnt",    sent_pkt_cnt, 64'd0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: len=10, num=2, gap=3, counter
    run(32'd2, 16'd10, 8'd3, 1'b0, 1'b0, -1, 1'b0);
    chk("s1_nbeats", q_data.size(), 64'd6);
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk("s1_data", {32'h0, q_data[i]}, i);
      chk("s1_keep", {60'h0, q_keep[i]}, (i % 3 == 2) ? 64'h3 : 64'hF);
      chk("s1_last", {63'h0, q_last[i]}, (i % 3 == 2) ? 64'd1 : 64'd0);
    end
    if (q_cyc.size() == 6) begin
      chk("s1_gap_spacing", q_cyc[3] - q_cyc[2], 64'd4);
      chk("s1_contig", q_cyc[2] - q_cyc[0], 64'd2);
    end
    chk("s1_cnt", sent_pkt_cnt, 64'd2);
    tick();
    chk("s1_cnt_hold", sent_pkt_cnt, 64'd2);

    // Scenario 2: len=8, gap=0, num=3 back-to-back
    run(32'd3, 16'd8, 8'd0, 1'b0, 1'b0, -1, 1'b0);
    chk("s2_nbeats", q_data.size(), 64'd6);
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk("s2_data", {32'h0, q_data[i]}, i);
      chk("s2_keep", {60'h0, q_keep[i]}, 64'hF);
      chk("s2_last", {63'h0, q_last[i]}, (i % 2 == 1) ? 64'd1 : 64'd0);
    end
    if (q_cyc.size() == 6) chk("s2_no_bubble", q_cyc[5] - q_cyc[0], 64'd5);
    chk("s2_cnt", sent_pkt_cnt, 64'd3);

    // Scenario 3: scenario 1 with tready toggling
    run(32'd2, 16'd10, 8'd3, 1'b0, 1'b1, -1, 1'b0);
    chk("s3_nbeats", q_data.size(), 64'd6);
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      chk("s3_data", {32'h0, q_data[i]}, i);
      chk("s3_keep", {60'h0, q_keep[i]}, (i % 3 == 2) ? 64'h3 : 64'hF);
      chk("s3_last", {63'h0, q_last[i]}, (i % 3 == 2) ? 64'd1 : 64'd0);
    end
    chk("s3_cnt", sent_pkt_cnt, 64'd2);

    // Scenario 4: LFSR payload, len=12, then restart
    run(32'd1, 16'd12, 8'd0, 1'b1, 1'b0, -1, 1'b0);
    chk("s4_nbeats", q_data.size(), 64'd3);
    if (q_data.size() == 3) begin
      chk("s4_beat0", {32'h0, q_data[0]}, 64'h0000_0001);
      chk("s4_beat1", {32'h0, q_data[1]}, 64'h8020_0003);
      chk("s4_beat2", {32'h0, q_data[2]}, 64'hC030_0002);
      chk("s4_keep2", {60'h0, q_keep[2]}, 64'hF);
      chk("s4_last2", {63'h0, q_last[2]}, 64'd1);
    end
    run(32'd1, 16'd12, 8'd0, 1'b1, 1'b0, -1, 1'b0);
    chk("s4r_nbeats", q_data.size(), 64'd3);
    if (q_data.size() == 3) begin
      chk("s4r_beat0", {32'h0, q_data[0]}, 64'h0000_0001);
      chk("s4r_beat1", {32'h0, q_data[1]}, 64'h8020_0003);
    end

    // Scenario 5: endless run, stop during packet 3
    run(32'd0, 16'd8, 8'd0, 1'b0, 1'b0, 4, 1'b0);
    chk("s5_nbeats", q_data.size(), 64'd6);
    if (q_data.size() == 6) begin
      chk("s5_last5", {63'h0, q_last[5]}, 64'd1);
      chk("s5_data5", {32'h0, q_data[5]}, 64'd5);
    end
    chk("s5_cnt", sent_pkt_cnt, 64'd3);

    // Start and stop together: one packet only
    run(32'd5, 16'd4, 8'd2, 1'b0, 1'b0, -1, 1'b1);
    chk("ss_nbeats", q_data.size(), 64'd1);
    chk("ss_cnt", sent_pkt_cnt, 64'd1);

    // Scenario 6: reset during beat 1
    pkt_num = 32'd0; pkt_len = 16'd8; gap_cycles = 8'd0; mode = 1'b0; m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6_beat0_data", {32'h0, m_axis_tdata}, 64'd0);
    tick();
    chk("s6_beat1_valid", {63'h0, m_axis_tvalid}, 64'd1);
    chk("s6_beat1_data", {32'h0, m_axis_tdata}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_tvalid", {63'h0, m_axis_tvalid}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s6_busy", {63'h0, busy}, 64'd0);
    chk("s6_cnt", sent_pkt_cnt, 64'd0);
    pkt_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s6_len0_busy", {63'h0, busy}, 64'd0);
    chk("s6_len0_tvalid", {63'h0, m_axis_tvalid}, 64'd0);
    tick();
    chk("s6_len0_busy2", {63'h0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
